ps2_scancode_decoder: RTL and testbench

//  Consumes raw PS/2 set-2 bytes, one-cycle pulse per byte, from keyboard_read (dataget/datarec).

---
 rtl/ps2_pkg.sv | 42 ++++
 rtl/ps2_ascii_lut.sv | 75 +++++++
 rtl/ps2_scancode_decoder.sv | 206 ++++++++++++++++++++
 tb/tb_ps2_scancode_decoder.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ---------------------------------------------------------------------------
// Package: ps2_pkg
// Shared types and constants for the PS/2 set-2 scancode decoder:
//   - decoder FSM state enum
//   - prefix bytes (E0 extended, F0 break, E1 pause)
//   - modifier key codes (shift, ctrl, caps lock)
//   - event record carried through the event FIFO
// ---------------------------------------------------------------------------
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXTBRK,
    ST_SKIP
  } ps2_state_e;

  localparam logic [7:0] PFX_EXT   = 8'hE0;
  localparam logic [7:0] PFX_BRK   = 8'hF0;
  localparam logic [7:0] PFX_PAUSE = 8'hE1;

  localparam logic [7:0] CODE_LSHIFT = 8'h12;
  localparam logic [7:0] CODE_RSHIFT = 8'h59;
  localparam logic [7:0] CODE_CTRL   = 8'h14;
  localparam logic [7:0] CODE_CAPS   = 8'h58;

  // Bytes that follow the leading E1 of the Pause sequence.
  localparam logic [2:0] PAUSE_TAIL_LEN = 3'd7;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
    logic [7:0] ascii;
  } ps2_evt_t;

  function automatic logic is_prefix(input logic [7:0] b);
    return (b == PFX_EXT) || (b == PFX_BRK) || (b == PFX_PAUSE);
  endfunction

endpackage

// File: rtl/ps2_ascii_lut.sv
// ---------------------------------------------------------------------------
// Module: ps2_ascii_lut
// Combinational map from a set-2 key code to ASCII.
// Ports:
//   i_code   in  8  key code with prefixes stripped
//   i_ext    in  1  code carried an E0 prefix (never mapped)
//   i_upper  in  1  letters map to uppercase
//   o_ascii  out 8  ASCII value, 0x00 when unmapped
// ---------------------------------------------------------------------------
module ps2_ascii_lut (
  input  logic [7:0] i_code,
  input  logic       i_ext,
  input  logic       i_upper,
  output logic [7:0] o_ascii
);

  logic [7:0] w_letter;  // lowercase letter, 0 when not a letter
  logic [7:0] w_fixed;   // digit / space / enter / backspace

  // NOTE: every signal driven here gets a default first so no path can infer a latch.
  always_comb begin
    w_letter = 8'h00;
    w_fixed  = 8'h00;
    case (i_code)
      8'h1C: w_letter = "a";
      8'h32: w_letter = "b";
      8'h21: w_letter = "c";
      8'h23: w_letter = "d";
      8'h24: w_letter = "e";
      8'h2B: w_letter = "f";
      8'h34: w_letter = "g";
      8'h33: w_letter = "h";
      8'h43: w_letter = "i";
      8'h3B: w_letter = "j";
      8'h42: w_letter = "k";
      8'h4B: w_letter = "l";
      8'h3A: w_letter = "m";
      8'h31: w_letter = "n";
      8'h44: w_letter = "o";
      8'h4D: w_letter = "p";
      8'h15: w_letter = "q";
      8'h2D: w_letter = "r";
      8'h1B: w_letter = "s";
      8'h2C: w_letter = "t";
      8'h3C: w_letter = "u";
      8'h2A: w_letter = "v";
      8'h1D: w_letter = "w";
      8'h22: w_letter = "x";
      8'h35: w_letter = "y";
      8'h1A: w_letter = "z";
      8'h45: w_fixed  = "0";
      8'h16: w_fixed  = "1";
      8'h1E: w_fixed  = "2";
      8'h26: w_fixed  = "3";
      8'h25: w_fixed  = "4";
      8'h2E: w_fixed  = "5";
      8'h36: w_fixed  = "6";
      8'h3D: w_fixed  = "7";
      8'h3E: w_fixed  = "8";
      8'h46: w_fixed  = "9";
      8'h29: w_fixed  = 8'h20;
      8'h5A: w_fixed  = 8'h0D;
      8'h66: w_fixed  = 8'h08;
      default: ;
    endcase

    if (i_ext)
      o_ascii = 8'h00;
    else if (w_letter != 8'h00)
      o_ascii = i_upper ? (w_letter - 8'h20) : w_letter;
    else
      o_ascii = w_fixed;
  end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// ---------------------------------------------------------------------------
// Module: ps2_scancode_decoder
// Folds raw PS/2 set-2 bytes (E0/F0/E1 prefixes) into key events, filters
// typematic repeats, tracks shift/ctrl/caps, attaches ASCII and queues the
// events in a small FIFO drained through a valid/ready port.
// Ports:
//   clk, rst (sync, active-high)
//   in_data[7:0], in_valid           raw byte strobe, no backpressure
//   evt_valid, evt_ready             FIFO head handshake
//   evt_code, evt_ext, evt_break,
//   evt_ascii                        head event fields (0 when empty)
//   shift_held, ctrl_held, caps_lock modifier state
//   key_count[7:0]                   pushed make events, wrapping
//   evt_overflow                     sticky: event dropped on full FIFO
// ---------------------------------------------------------------------------
module ps2_scancode_decoder
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH    = 4,
  parameter int FILTER_REPEAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [7:0] evt_code,
  output logic       evt_ext,
  output logic       evt_break,
  output logic [7:0] evt_ascii,
  output logic       shift_held,
  output logic       ctrl_held,
  output logic       caps_lock,
  output logic [7:0] key_count,
  output logic       evt_overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);

  // ---------------- prefix FSM ----------------
  ps2_state_e r_state, w_state_nxt;
  logic [2:0] r_skip_cnt;
  logic       w_emit, w_ext, w_brk;

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (in_valid) begin
      unique case (r_state)
        ST_IDLE: begin
          if (in_data == PFX_EXT)        w_state_nxt = ST_EXT;
          else if (in_data == PFX_BRK)   w_state_nxt = ST_BRK;
          else if (in_data == PFX_PAUSE) w_state_nxt = ST_SKIP;
        end
        ST_EXT: begin
          if (in_data == PFX_BRK)        w_state_nxt = ST_EXTBRK;
          else if (!is_prefix(in_data))  w_state_nxt = ST_IDLE;
        end
        ST_BRK, ST_EXTBRK: begin
          if (!is_prefix(in_data))       w_state_nxt = ST_IDLE;
        end
        ST_SKIP: begin
          if (r_skip_cnt <= 3'd1)        w_state_nxt = ST_IDLE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_emit = 1'b0;
    w_ext  = 1'b0;
    w_brk  = 1'b0;
    if (in_valid && !is_prefix(in_data)) begin
      case (r_state)
        ST_IDLE:   w_emit = 1'b1;
        ST_EXT:    begin w_emit = 1'b1; w_ext = 1'b1; end
        ST_BRK:    begin w_emit = 1'b1; w_brk = 1'b1; end
        ST_EXTBRK: begin w_emit = 1'b1; w_ext = 1'b1; w_brk = 1'b1; end
        default: ;
      endcase
    end
  end

  // Counts down the Pause tail so its bytes never reach the event path.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_skip_cnt <= 3'd0;
    end else if (in_valid) begin
      if (r_state == ST_IDLE && in_data == PFX_PAUSE) r_skip_cnt <= PAUSE_TAIL_LEN;
      else if (r_state == ST_SKIP)                    r_skip_cnt <= r_skip_cnt - 3'd1;
    end
  end

  // ---------------- repeat filter ----------------
  logic       r_held_valid, r_held_ext;
  logic [7:0] r_held_code;
  logic       w_held_hit, w_accept;

  assign w_held_hit = r_held_valid && (r_held_ext == w_ext) && (r_held_code == in_data);
  assign w_accept   = w_emit && !((FILTER_REPEAT != 0) && !w_brk && w_held_hit);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_held_valid <= 1'b0;
      r_held_ext   <= 1'b0;
      r_held_code  <= 8'h00;
    end else if (w_accept) begin
      if (!w_brk) begin
        r_held_valid <= 1'b1;
        r_held_ext   <= w_ext;
        r_held_code  <= in_data;
      end else if (w_held_hit) begin
        r_held_valid <= 1'b0;
      end
    end
  end

  // ---------------- modifiers ----------------
  logic r_lshift, r_rshift, r_lctrl, r_rctrl, r_caps;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lshift <= 1'b0;
      r_rshift <= 1'b0;
      r_lctrl  <= 1'b0;
      r_rctrl  <= 1'b0;
      r_caps   <= 1'b0;
    end else if (w_accept && !w_ext) begin
      case (in_data)
        CODE_LSHIFT: r_lshift <= !w_brk;
        CODE_RSHIFT: r_rshift <= !w_brk;
        CODE_CTRL:   r_lctrl  <= !w_brk;
        CODE_CAPS:   if (!w_brk) r_caps <= !r_caps;
        default: ;
      endcase
    end else if (w_accept && w_ext && in_data == CODE_CTRL) begin
      r_rctrl <= !w_brk;
    end
  end

  assign shift_held = r_lshift | r_rshift;
  assign ctrl_held  = r_lctrl | r_rctrl;
  assign caps_lock  = r_caps;

  // ASCII sees the modifier state from before this event.
  logic [7:0] w_ascii;

  ps2_ascii_lut u_ascii_lut (
    .i_code  (in_data),
    .i_ext   (w_ext),
    .i_upper (shift_held ^ r_caps),
    .o_ascii (w_ascii)
  );

  // ---------------- event FIFO ----------------
  ps2_evt_t   r_mem [FIFO_DEPTH];
  ps2_evt_t   w_new_evt, w_head;
  logic [AW:0] r_wr_ptr, r_rd_ptr;
  logic       w_empty, w_full, w_pop, w_push;
  logic [7:0] r_key_count;
  logic       r_overflow;

  assign w_new_evt = '{ext: w_ext, brk: w_brk, code: in_data, ascii: w_ascii};
  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop     = !w_empty && evt_ready;
  assign w_push    = w_accept && (!w_full || w_pop);

  // NOTE: the storage array has no reset; pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= w_new_evt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_key_count <= 8'h00;
      r_overflow  <= 1'b0;
    end else begin
      if (w_push)                        r_wr_ptr    <= r_wr_ptr + 1'b1;
      if (w_pop)                         r_rd_ptr    <= r_rd_ptr + 1'b1;
      if (w_push && !w_brk)              r_key_count <= r_key_count + 8'd1;
      if (w_accept && w_full && !w_pop)  r_overflow  <= 1'b1;
    end
  end

  // Head is forced to zero when empty so unwritten storage never shows.
  assign w_head       = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
  assign evt_valid    = !w_empty;
  assign evt_code     = w_head.code;
  assign evt_ext      = w_head.ext;
  assign evt_break    = w_head.brk;
  assign evt_ascii    = w_head.ascii;
  assign key_count    = r_key_count;
  assign evt_overflow = r_overflow;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
module tb_ps2_scancode_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       evt_valid, evt_ready;
  logic [7:0] evt_code, evt_ascii, key_count;
  logic       evt_ext, evt_break;
  logic       shift_held, ctrl_held, caps_lock, evt_overflow;

  int n_checks = 0;
  int n_fail   = 0;

  ps2_scancode_decoder #(
    .FIFO_DEPTH    (4),
    .FILTER_REPEAT (1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .evt_valid    (evt_valid),
    .evt_ready    (evt_ready),
    .evt_code     (evt_code),
    .evt_ext      (evt_ext),
    .evt_break    (evt_break),
    .evt_ascii    (evt_ascii),
    .shift_held   (shift_held),
    .ctrl_held    (ctrl_held),
    .caps_lock    (caps_lock),
    .key_count    (key_count),
    .evt_overflow (evt_overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Byte is sampled at the posedge following this negedge.
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  initial begin
    // Reset with a byte strobed at the same time: reset must win.
    rst = 1'b1; in_valid = 1'b1; in_data = 8'h1C; evt_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    check("rst_valid",    evt_valid,    0);
    check("rst_code",     evt_code,     0);
    check("rst_count",    key_count,    0);
    check("rst_shift",    shift_held,   0);
    check("rst_ctrl",     ctrl_held,    0);
    check("rst_caps",     caps_lock,    0);
    check("rst_ovf",      evt_overflow, 0);

    // 1: plain make of 'a'
    send(8'h1C); idle();
    check("t1_valid", evt_valid, 1);
    check("t1_code",  evt_code,  8'h1C);
    check("t1_ext",   evt_ext,   0);
    check("t1_brk",   evt_break, 0);
    check("t1_ascii", evt_ascii, 8'h61);
    check("t1_count", key_count, 8'h01);
    idle();
    check("t1_drained", evt_valid, 0);
    send(8'hF0); send(8'h1C); idle();
    check("t1_rel_brk",   evt_break, 1);
    check("t1_rel_ascii", evt_ascii, 8'h61);
    idle();

    // 2: shift modifies letter case
    send(8'h12); idle();
    check("t2_shift_on", shift_held, 1);
    check("t2_sh_code",  evt_code,   8'h12);
    check("t2_sh_ascii", evt_ascii,  8'h00);
    check("t2_count_a",  key_count,  8'h02);
    idle();
    send(8'h1C); idle();
    check("t2_upper_A", evt_ascii, 8'h41);
    check("t2_count_b", key_count, 8'h03);
    idle();
    send(8'hF0); send(8'h12); idle();
    check("t2_brk",       evt_break,  1);
    check("t2_brk_code",  evt_code,   8'h12);
    check("t2_shift_off", shift_held, 0);
    check("t2_count_c",   key_count,  8'h03);
    idle();
    send(8'hF0); send(8'h1C); idle();
    check("t2_rel_ascii", evt_ascii, 8'h61);
    idle();

    // 3: right ctrl via E0
    send(8'hE0); send(8'h14); idle();
    check("t3_ctrl_on", ctrl_held, 1);
    check("t3_ext",     evt_ext,   1);
    check("t3_code",    evt_code,  8'h14);
    check("t3_count",   key_count, 8'h04);
    idle();
    send(8'hE0); send(8'hF0); send(8'h14); idle();
    check("t3_ctrl_off", ctrl_held, 0);
    check("t3_brk_ext",  evt_ext,   1);
    check("t3_brk",      evt_break, 1);
    check("t3_brk_code", evt_code,  8'h14);
    idle();

    // 4: typematic repeats back-to-back are suppressed
    send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C); idle();
    check("t4_brk_head", evt_break, 1);
    check("t4_code",     evt_code,  8'h1C);
    check("t4_count",    key_count, 8'h05);
    idle();
    check("t4_drained", evt_valid, 0);

    // 5: fill FIFO with consumer stalled, fifth event overflows
    evt_ready = 1'b0;
    send(8'h15); send(8'h1D); send(8'h24); send(8'h2D); send(8'h2C); idle();
    check("t5_ovf",    evt_overflow, 1);
    check("t5_valid",  evt_valid,    1);
    check("t5_head0",  evt_code,     8'h15);
    check("t5_ascii0", evt_ascii,    8'h71);
    check("t5_count",  key_count,    8'h09);
    idle();
    check("t5_stable", evt_code, 8'h15);
    evt_ready = 1'b1;
    @(negedge clk);
    check("t5_head1",  evt_code,  8'h1D);
    check("t5_ascii1", evt_ascii, 8'h77);
    @(negedge clk);
    check("t5_head2",  evt_code,  8'h24);
    @(negedge clk);
    check("t5_head3",  evt_code,  8'h2D);
    @(negedge clk);
    check("t5_empty",  evt_valid, 0);

    // caps lock, shift xor caps, digits, extended codes
    send(8'h58); idle();
    check("caps_on",    caps_lock, 1);
    check("caps_ascii", evt_ascii, 8'h00);
    check("caps_count", key_count, 8'h0A);
    idle();
    send(8'h1C); idle();
    check("caps_A", evt_ascii, 8'h41);
    idle();
    send(8'h12); send(8'h1C); idle();
    check("shcaps_a",     evt_ascii,  8'h61);
    check("shcaps_shift", shift_held, 1);
    check("shcaps_count", key_count,  8'h0D);
    idle();
    send(8'h16); idle();
    check("digit_1", evt_ascii, 8'h31);
    idle();
    send(8'hE0); send(8'h5A); idle();
    check("kp_enter_ext",   evt_ext,   1);
    check("kp_enter_code",  evt_code,  8'h5A);
    check("kp_enter_ascii", evt_ascii, 8'h00);
    check("kp_enter_count", key_count, 8'h0F);
    idle();

    // 6: Pause sequence produces nothing, following key decodes normally
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77); idle();
    check("t6_no_evt",   evt_valid, 0);
    check("t6_count",    key_count, 8'h0F);
    check("t6_ctrl",     ctrl_held, 0);
    send(8'h1C); idle();
    check("t6_after",       evt_code,  8'h1C);
    check("t6_after_ext",   evt_ext,   0);
    check("t6_after_ascii", evt_ascii, 8'h61);
    check("t6_after_count", key_count, 8'h10);
    idle();

    // Reset mid-prefix drops the pending E0
    send(8'hE0);
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    send(8'h1C); idle();
    check("rstmid_ext",   evt_ext,    0);
    check("rstmid_code",  evt_code,   8'h1C);
    check("rstmid_count", key_count,  8'h01);
    check("rstmid_caps",  caps_lock,  0);
    check("rstmid_shift", shift_held, 0);
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
